// File: rtl/n64_joybus_tx_pkg.sv
// ---------------------------------------------------------------------------
// n64_joybus_tx_pkg
// Shared Joybus definitions for the controller-line transmitter.
//   - Command bytes used when polling or resetting a controller.
//   - Bit timing in microsecond quanta: every bit cell is JB_BIT_US long and
//     starts low; a '1' keeps the line low for JB_SHORT_US, a '0' for
//     JB_LONG_US.
//   - Synchroniser latency of the line readback path.
//   - Transmitter state encoding.
//   - Helpers returning the low / high part of a bit cell in microseconds.
// ---------------------------------------------------------------------------
package n64_joybus_tx_pkg;

  localparam logic [7:0] JB_CMD_INFO  = 8'h00;
  localparam logic [7:0] JB_CMD_POLL  = 8'h01;
  localparam logic [7:0] JB_CMD_RESET = 8'hFF;

  localparam int unsigned JB_BIT_US   = 32'd4;
  localparam int unsigned JB_SHORT_US = 32'd1;
  localparam int unsigned JB_LONG_US  = 32'd3;

  // Cycles between a pin change and its appearance on the synchronised line.
  localparam int unsigned SYNC_LAT = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GUARD = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_STOP  = 3'd4
  } jb_state_e;

  // Low part of a bit cell: a '1' is a short low pulse, a '0' a long one.
  function automatic int unsigned jb_low_us(input logic bit_val);
    return bit_val ? JB_SHORT_US : JB_LONG_US;
  endfunction

  // High part of a bit cell: whatever remains of the cell after the low part.
  function automatic int unsigned jb_high_us(input logic bit_val);
    return JB_BIT_US - jb_low_us(bit_val);
  endfunction

endpackage

// File: rtl/n64_joybus_tx_sync.sv
// ---------------------------------------------------------------------------
// n64_joybus_tx_sync
// Two-flop synchroniser (register_sync) for the asynchronous CTRL line
// readback. The output follows the input two clock edges later.
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   d      in  1  asynchronous input
//   q      out 1  synchronised output
// Both flops reset to RESET_VAL; for the open-drain line that is the idle
// (pulled-up) level, so no phantom low is seen right after reset.
// ---------------------------------------------------------------------------
module n64_joybus_tx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/n64_joybus_tx.sv
// ---------------------------------------------------------------------------
// n64_joybus_tx
// Joybus transmitter: serialises 1..MAX_BYTES bytes followed by a stop bit
// onto the open-drain controller line. The pad is driven as
// pin = CTRL_oe_o ? 1'b0 : 1'bz by the level above.
// Ports:
//   CTRL_CLK    in   1            clock (single domain)
//   CTRL_nRST   in   1            asynchronous active-low reset
//   CTRL_i      in   1            line readback, asynchronous
//   tx_start_i  in   1            single-cycle frame request
//   tx_len_i    in   3            byte count, accepted when 1..MAX_BYTES
//   tx_data_i   in   8*MAX_BYTES  byte0 = [7:0] goes first, each byte MSB first
//   tx_busy_o   out  1            frame accepted and in progress
//   tx_done_o   out  1            one-cycle pulse on normal completion
//   tx_abort_o  out  1            one-cycle pulse on collision abort
//   CTRL_oe_o   out  1            1 = pull the line low
// Parameters:
//   CLKS_PER_US   clock cycles per 1 us bit quantum
//   MAX_BYTES     longest frame in bytes
//   GUARD_CYCLES  consecutive high cycles required before driving
//   STOP_LOW_US   stop-bit low time (1 = console stop, 2 = controller stop)
// ---------------------------------------------------------------------------
module n64_joybus_tx
  import n64_joybus_tx_pkg::*;
#(
  parameter int CLKS_PER_US  = 4,
  parameter int MAX_BYTES    = 4,
  parameter int GUARD_CYCLES = 255,
  parameter int STOP_LOW_US  = 1
) (
  input  logic                   CTRL_CLK,
  input  logic                   CTRL_nRST,
  input  logic                   CTRL_i,
  input  logic                   tx_start_i,
  input  logic [2:0]             tx_len_i,
  input  logic [8*MAX_BYTES-1:0] tx_data_i,
  output logic                   tx_busy_o,
  output logic                   tx_done_o,
  output logic                   tx_abort_o,
  output logic                   CTRL_oe_o
);

  localparam int DW   = 8 * MAX_BYTES;
  localparam int PH_W = $clog2(3 * CLKS_PER_US + 1);
  localparam int BC_W = $clog2(8 * MAX_BYTES + 1);
  localparam int GD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [2:0]      MAX_LEN     = 3'(MAX_BYTES);
  localparam logic [GD_W-1:0] GUARD_SAT   = GD_W'(GUARD_CYCLES);
  localparam logic [PH_W-1:0] STOP_RELOAD = PH_W'(STOP_LOW_US * CLKS_PER_US - 1);
  // Released line needs SYNC_LAT cycles to show up high on the synced input;
  // sampling earlier would see our own low and flag a false collision.
  localparam logic [PH_W-1:0] COLL_MIN    = PH_W'(SYNC_LAT + 32'd1);

  // Phase counter reload for the low part of a bit (counts down to zero).
  function automatic logic [PH_W-1:0] low_reload(input logic bit_val);
    return PH_W'(jb_low_us(bit_val) * CLKS_PER_US - 1);
  endfunction

  // Phase counter reload for the high part of a bit.
  function automatic logic [PH_W-1:0] high_reload(input logic bit_val);
    return PH_W'(jb_high_us(bit_val) * CLKS_PER_US - 1);
  endfunction

  jb_state_e       state_r;
  logic [PH_W-1:0] phase_r;
  logic [BC_W-1:0] bit_cnt_r;
  logic [DW-1:0]   shift_r;
  logic [GD_W-1:0] guard_r;
  logic            busy_r;
  logic            done_r;
  logic            abort_r;
  logic            oe_r;

  logic            line_s;
  logic            cur_bit_s;
  logic            phase_zero_s;
  logic [PH_W-1:0] high_elapsed_s;
  logic            collision_s;
  logic            stop_end_s;
  logic            frame_end_s;
  logic            len_ok_s;
  logic            guard_sat_s;
  logic            byte_done_s;
  logic [DW-1:0]   next_shift_s;
  logic            next_bit_s;

  n64_joybus_tx_sync #(
    .RESET_VAL (1'b1)
  ) u_line_sync (
    .clk   (CTRL_CLK),
    .rst_n (CTRL_nRST),
    .d     (CTRL_i),
    .q     (line_s)
  );

  // Per-cycle decode of counters, collision window and start qualification.
  always_comb begin
    cur_bit_s      = shift_r[7];
    phase_zero_s   = (phase_r == {PH_W{1'b0}});
    // Elapsed cycles in the high phase, recovered from the down counter.
    high_elapsed_s = high_reload(cur_bit_s) - phase_r;
    collision_s    = (state_r == ST_HIGH) && (high_elapsed_s >= COLL_MIN) && !line_s;
    stop_end_s     = (state_r == ST_STOP) && phase_zero_s;
    frame_end_s    = collision_s || stop_end_s;
    len_ok_s       = (tx_len_i != 3'd0) && (tx_len_i <= MAX_LEN);
    guard_sat_s    = (guard_r == GUARD_SAT);
    // The bit in flight is the last one of its byte when the remaining count
    // is 1 modulo 8 (count was loaded with a multiple of 8).
    byte_done_s    = (bit_cnt_r[2:0] == 3'd1);
  end

  // Next shift-register content: shift inside the byte, or drop to the next byte.
  always_comb begin
    next_shift_s = shift_r;
    if (byte_done_s) begin
      next_shift_s = shift_r >> 4'd8;
    end else begin
      next_shift_s[7:0] = {shift_r[6:0], 1'b0};
    end
    next_bit_s = next_shift_s[7];
  end

  // Guard counter: counts consecutive synced-high cycles, restarts after each frame.
  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      guard_r <= {GD_W{1'b0}};
    end else if (frame_end_s) begin
      guard_r <= {GD_W{1'b0}};
    end else if (!line_s) begin
      guard_r <= {GD_W{1'b0}};
    end else if (!guard_sat_s) begin
      guard_r <= guard_r + GD_W'(1);
    end
  end

  // Transmit FSM with phase/bit timers and registered line/status outputs.
  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      state_r   <= ST_IDLE;
      phase_r   <= {PH_W{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
      shift_r   <= {DW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      oe_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (tx_start_i && len_ok_s) begin
            shift_r   <= tx_data_i;
            bit_cnt_r <= BC_W'({tx_len_i, 3'b000});
            busy_r    <= 1'b1;
            state_r   <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          if (guard_sat_s) begin
            oe_r    <= 1'b1;
            phase_r <= low_reload(cur_bit_s);
            state_r <= ST_LOW;
          end
        end

        ST_LOW: begin
          if (phase_zero_s) begin
            oe_r    <= 1'b0;
            phase_r <= high_reload(cur_bit_s);
            state_r <= ST_HIGH;
          end else begin
            phase_r <= phase_r - PH_W'(1);
          end
        end

        ST_HIGH: begin
          if (collision_s) begin
            // Someone else holds the line low: back off without a done pulse.
            oe_r    <= 1'b0;
            abort_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (phase_zero_s) begin
            oe_r <= 1'b1;
            if (bit_cnt_r > BC_W'(1)) begin
              bit_cnt_r <= bit_cnt_r - BC_W'(1);
              shift_r   <= next_shift_s;
              phase_r   <= low_reload(next_bit_s);
              state_r   <= ST_LOW;
            end else begin
              bit_cnt_r <= {BC_W{1'b0}};
              phase_r   <= STOP_RELOAD;
              state_r   <= ST_STOP;
            end
          end else begin
            phase_r <= phase_r - PH_W'(1);
          end
        end

        ST_STOP: begin
          if (phase_zero_s) begin
            oe_r    <= 1'b0;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            phase_r <= phase_r - PH_W'(1);
          end
        end

        default: begin
          oe_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_busy_o  = busy_r;
  assign tx_done_o  = done_r;
  assign tx_abort_o = abort_r;
  assign CTRL_oe_o  = oe_r;

endmodule

// File: tb/tb_n64_joybus_tx.sv
// ---------------------------------------------------------------------------
// tb_n64_joybus_tx
// Directed bench for the Joybus transmitter. The stimulus side pushes the
// expected outcome of each frame into a queue; a monitor decodes the open-drain
// line like a controller sniffer and, on every done/abort pulse, pops and
// compares event kind, bit count, decoded bytes, pulse widths and duration.
// ---------------------------------------------------------------------------
module tb_n64_joybus_tx;
  import n64_joybus_tx_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  len   = 3'd0;
  logic [31:0] data  = 32'd0;
  logic        pull  = 1'b0;
  logic        busy;
  logic        done;
  logic        abort;
  logic        oe;
  logic        line;

  // Open-drain bus with pull-up: low when the DUT or the bench drives it.
  assign line = ~(oe | pull);

  always #5 clk = ~clk;

  n64_joybus_tx #(
    .CLKS_PER_US  (4),
    .MAX_BYTES    (4),
    .GUARD_CYCLES (255),
    .STOP_LOW_US  (1)
  ) dut (
    .CTRL_CLK   (clk),
    .CTRL_nRST  (rst_n),
    .CTRL_i     (line),
    .tx_start_i (start),
    .tx_len_i   (len),
    .tx_data_i  (data),
    .tx_busy_o  (busy),
    .tx_done_o  (done),
    .tx_abort_o (abort),
    .CTRL_oe_o  (oe)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_abort;
    int          nbits;
    logic [31:0] data;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_done(input logic [2:0] l, input logic [31:0] d);
    exp_t        e;
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 8 * int'(l); i++) m[i] = 1'b1;
    e.is_abort = 1'b0;
    e.nbits    = 8 * int'(l) + 1;
    e.data     = d & m;
    e.cycles   = 128 * int'(l) + 4;
    exp_q.push_back(e);
  endtask

  task automatic expect_abort(input int nb);
    exp_t e;
    e.is_abort = 1'b1;
    e.nbits    = nb;
    e.data     = 32'd0;
    e.cycles   = 0;
    exp_q.push_back(e);
  endtask

  // Sniffer state
  int low_run   = 0;
  int frame_cyc = 0;
  int nbits     = 0;
  bit in_frame  = 1'b0;
  bit bits [64];
  int lows [64];

  task automatic score();
    exp_t        e;
    logic [31:0] dec;
    int          bad;
    int          want;
    int          lim;
    logic        eb;
    check("pulse_exclusive", {31'd0, done & abort}, 32'd0);
    if (exp_q.size() == 0) begin
      check("unexpected_pulse", {30'd0, abort, done}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", {31'd0, abort}, {31'd0, e.is_abort});
      check("busy_at_end", {31'd0, busy}, 32'd0);
      check("oe_at_end", {31'd0, oe}, 32'd0);
      if (!e.is_abort) begin
        check("frame_cycles", frame_cyc, e.cycles);
        check("bit_count", nbits, e.nbits);
        dec = 32'd0;
        for (int i = 0; i < e.nbits - 1 && i < nbits && i < 32; i++)
          dec[(i / 8) * 8 + 7 - (i % 8)] = bits[i];
        check("decoded_data", dec, e.data);
        bad = 0;
        lim = (nbits < e.nbits) ? nbits : e.nbits;
        for (int i = 0; i < lim && i < 64; i++) begin
          eb   = (i < 32) ? e.data[(i / 8) * 8 + 7 - (i % 8)] : 1'b0;
          want = (i == e.nbits - 1) ? 4 : (eb ? 4 : 12);
          if (lows[i] != want) bad++;
        end
        check("low_timing_errors", bad, 0);
      end else begin
        check("abort_bit_count", nbits, e.nbits);
      end
    end
    in_frame = 1'b0;
    low_run  = 0;
  endtask

  // Monitor: sample the line on falling clock edges, decode pulses, score events.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_run   = 0;
        in_frame  = 1'b0;
        nbits     = 0;
        frame_cyc = 0;
      end else begin
        if (in_frame) frame_cyc++;
        if (!line && !pull) begin
          if (!in_frame) begin
            in_frame  = 1'b1;
            frame_cyc = 0;
            nbits     = 0;
          end
          low_run++;
        end else if (low_run > 0) begin
          if (nbits < 64) begin
            bits[nbits] = (low_run <= 8);
            lows[nbits] = low_run;
          end
          nbits++;
          low_run = 0;
        end
        if (done || abort) score();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] l, input logic [31:0] d, input bit exp_frame);
    tick();
    len   = l;
    data  = d;
    start = 1'b1;
    if (exp_frame) expect_done(l, d);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
    check("frame_completed", exp_q.size(), 32'd0);
    repeat (4) tick();
  endtask

  task automatic wait_oe_rise(input string name);
    int n = 0;
    while (!oe && n < 1000) begin
      tick();
      n++;
    end
    check(name, {31'd0, oe}, 32'd1);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, busy, done, abort, oe}, 32'd0);
    rst_n = 1'b1;
    repeat (300) tick();

    // 1: single poll byte on an idle line
    send(3'd1, {24'd0, JB_CMD_POLL}, 1'b1);
    wait_idle(2000);

    // 2: three bytes decoded in order; a second start while busy is ignored
    send(3'd3, 32'h0000_4002, 1'b1);
    repeat (20) tick();
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    send(3'd1, 32'h0000_00AA, 1'b0);
    wait_idle(3000);

    // 6: invalid lengths are ignored
    send(3'd0, 32'h0000_00FF, 1'b0);
    repeat (5) tick();
    check("len0_ignored", {31'd0, busy}, 32'd0);
    send(3'd5, 32'h0000_00FF, 1'b0);
    repeat (5) tick();
    check("len5_ignored", {31'd0, busy}, 32'd0);

    // 3: line held low, frame waits for the full guard interval after release
    pull = 1'b1;
    repeat (10) tick();
    send(3'd1, 32'h0000_00A5, 1'b1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (oe) cnt++;
    end
    check("oe_while_held_low", cnt, 32'd0);
    pull = 1'b0;
    cnt  = 0;
    while (!oe && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("guard_latency", cnt, 32'd258);
    wait_idle(2000);

    // 4: collision during the high part of bit 2
    send(3'd1, {24'd0, JB_CMD_RESET}, 1'b0);
    expect_abort(3);
    wait_oe_rise("oe_rise_t4");
    repeat (41) tick();
    pull = 1'b1;
    repeat (8) tick();
    pull = 1'b0;
    wait_idle(200);
    repeat (300) tick();

    // 5: asynchronous reset during bit 5, then a full frame
    send(3'd2, 32'h0000_C3A5, 1'b0);
    wait_oe_rise("oe_rise_t5");
    repeat (86) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, busy, done, abort, oe}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    send(3'd2, 32'h0000_5A0F, 1'b1);
    wait_idle(2000);

    repeat (20) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit
  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=expired required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
